aclint_timer_ctrl: RTL and testbench

Memory-mapped machine-level timer and software-interrupt controller (ACLINT MTIMER + MSWI) for a single hart. It owns the `mtime`, `mtimecmp` and `msip` registers and serves the core's data bus with a one-request-at-a-time handshake. It drives the `mtip`, `msip` and `mtime` signals that the CSR unit reads through its `aclint` interface. Those signals feed the `mip` bits and the `TIME` CSR.

---
 rtl/aclint_timer_ctrl_if.sv | 23 ++
 rtl/aclint_timer_ctrl.sv | 152 +++++++++++++++
 tb/tb_aclint_timer_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aclint_timer_ctrl_if.sv
// Core data-bus port of the ACLINT timer block: one request in flight at a time,
// response is a single-cycle rvalid pulse with no back-pressure.
interface aclint_timer_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rvalid;
  logic [63:0] rdata;
  logic        rerr;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, rvalid, rdata, rerr
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, rvalid, rdata, rerr
  );
endinterface

// File: rtl/aclint_timer_ctrl.sv
// ACLINT MTIMER + MSWI for one hart: mtime/mtimecmp/msip behind a 64 KiB window.
// Response one cycle after accept; req_ready drops during the response cycle, no response stall.
module aclint_timer_ctrl #(
  parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  aclint_timer_ctrl_if.slave  bus,
  output logic                mtip,
  output logic                msip,
  output logic [63:0]         mtime
);

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME    = 16'hBFF8;
  localparam logic [15:0] DIV_LAST     = 16'(MTIME_DIV - 1);

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME} sel_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        rerr;
  } resp_t;

  state_t      state_q, state_d;
  resp_t       resp_q, resp_d;
  sel_t        sel;
  logic        accept;
  logic        wr_any;
  logic        wr_msip, wr_mtimecmp, wr_mtime;
  logic        presc_wrap;
  logic [63:0] byte_mask;
  logic [63:0] old_val;
  logic [63:0] merged;
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        msip_q;
  logic [15:0] presc_q;

  // Address decode; misaligned and out-of-window accesses fall through to SEL_NONE.
  always_comb begin
    sel = SEL_NONE;
    if ((bus.req_addr[63:16] == BASE_ADDR[63:16]) && (bus.req_addr[2:0] == 3'b000)) begin
      case (bus.req_addr[15:0])
        OFF_MSIP:     sel = SEL_MSIP;
        OFF_MTIMECMP: sel = SEL_MTIMECMP;
        OFF_MTIME:    sel = SEL_MTIME;
        default:      sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    old_val = 64'd0;
    case (sel)
      SEL_MSIP:     old_val = {63'd0, msip_q};
      SEL_MTIMECMP: old_val = mtimecmp_q;
      SEL_MTIME:    old_val = mtime_q;
      default:      old_val = 64'd0;
    endcase
  end

  always_comb begin
    byte_mask = 64'd0;
    for (int b = 0; b < 8; b++) begin
      byte_mask[8*b +: 8] = {8{bus.req_wmask[b]}};
    end
  end

  assign merged = (bus.req_wdata & byte_mask) | (old_val & ~byte_mask);

  always_comb begin
    resp_d.rdata = old_val;
    resp_d.rerr  = (sel == SEL_NONE);
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rvalid    = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rvalid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // An all-zero mask must leave mtime and the prescaler phase untouched.
  assign wr_any      = accept && bus.req_wen;
  assign wr_msip     = wr_any && (sel == SEL_MSIP) && bus.req_wmask[0];
  assign wr_mtimecmp = wr_any && (sel == SEL_MTIMECMP);
  assign wr_mtime    = wr_any && (sel == SEL_MTIME) && (bus.req_wmask != 8'h00);
  assign presc_wrap  = (presc_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        resp_q <= resp_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= 64'd0;
      presc_q    <= 16'd0;
    end else begin
      if (wr_msip) begin
        msip_q <= bus.req_wdata[0];
      end
      if (wr_mtimecmp) begin
        mtimecmp_q <= merged;
      end
      // A bus write to mtime beats the tick and restarts the prescaler.
      if (wr_mtime) begin
        mtime_q <= merged;
        presc_q <= 16'd0;
      end else if (presc_wrap) begin
        mtime_q <= mtime_q + 64'd1;
        presc_q <= 16'd0;
      end else begin
        presc_q <= presc_q + 16'd1;
      end
    end
  end

  assign bus.rdata = resp_q.rdata;
  assign bus.rerr  = resp_q.rerr;
  assign mtip      = (mtime_q >= mtimecmp_q);
  assign msip      = msip_q;
  assign mtime     = mtime_q;

endmodule

// File: tb/tb_aclint_timer_ctrl.sv
// Scoreboard bench: two instances (MTIME_DIV 1 and 4) driven by directed and random requests,
// checked against an mtime model expressed as anchor value plus elapsed cycles / divider.
module tb_aclint_timer_ctrl;
  localparam logic [63:0] BASE = 64'h0200_0000;

  typedef struct packed {
    logic [63:0] rdata;
    logic        rerr;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   model_ok = 1'b0;

  logic [1:0]        rv = '0;
  logic [1:0][63:0]  ra = '0;
  logic [1:0]        rw = '0;
  logic [1:0][63:0]  rwd = '0;
  logic [1:0][7:0]   rm = '0;
  logic [1:0]        rdy_o, rvalid_o, rerr_o, mtip_o, msip_o;
  logic [1:0][63:0]  rdata_o, mtime_o;

  logic [63:0] anc_v [2];
  int          anc_e [2];
  logic [63:0] cmp_m [2];
  logic        msip_m [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        mon_e;

  aclint_timer_ctrl_if bus0 ();
  aclint_timer_ctrl_if bus1 ();

  assign bus0.req_valid = rv[0];
  assign bus0.req_addr  = ra[0];
  assign bus0.req_wen   = rw[0];
  assign bus0.req_wdata = rwd[0];
  assign bus0.req_wmask = rm[0];
  assign bus1.req_valid = rv[1];
  assign bus1.req_addr  = ra[1];
  assign bus1.req_wen   = rw[1];
  assign bus1.req_wdata = rwd[1];
  assign bus1.req_wmask = rm[1];
  assign rdy_o    = {bus1.req_ready, bus0.req_ready};
  assign rvalid_o = {bus1.rvalid, bus0.rvalid};
  assign rerr_o   = {bus1.rerr, bus0.rerr};
  assign rdata_o  = {bus1.rdata, bus0.rdata};

  aclint_timer_ctrl #(.BASE_ADDR(BASE), .MTIME_DIV(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .mtip(mtip_o[0]), .msip(msip_o[0]), .mtime(mtime_o[0])
  );

  aclint_timer_ctrl #(.BASE_ADDR(BASE), .MTIME_DIV(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .mtip(mtip_o[1]), .msip(msip_o[1]), .mtime(mtime_o[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] ref_mtime(input int i, input int n);
    return anc_v[i] + 64'((n - anc_e[i]) / div_of(i));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: responses are popped from the scoreboard; outputs compared to the model every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rvalid_o[i] === 1'b1) begin
        if (((i == 0) ? q0.size() : q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid[%0d]: got rvalid=1, expected no response (cycle %0d)", i, cyc);
        end else begin
          if (i == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          chk($sformatf("rdata[%0d]", i), rdata_o[i], mon_e.rdata);
          chk($sformatf("rerr[%0d]", i), 64'(rerr_o[i]), 64'(mon_e.rerr));
          chk($sformatf("resp_cycle[%0d]", i), 64'(cyc), 64'(mon_e.cyc));
        end
      end else if (i == 0 && q0.size() > 0 && int'(q0[0].cyc) <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid[0]: got rvalid=0, expected response in cycle %0d", q0[0].cyc);
        void'(q0.pop_front());
      end else if (i == 1 && q1.size() > 0 && int'(q1[0].cyc) <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid[1]: got rvalid=0, expected response in cycle %0d", q1[0].cyc);
        void'(q1.pop_front());
      end
      if (model_ok) begin
        chk($sformatf("mtime[%0d]", i), mtime_o[i], ref_mtime(i, cyc));
        chk($sformatf("mtip[%0d]", i), 64'(mtip_o[i]), 64'(ref_mtime(i, cyc) >= cmp_m[i]));
        chk($sformatf("msip[%0d]", i), 64'(msip_o[i]), 64'(msip_m[i]));
      end
    end
  end

  task automatic do_reset(input int n);
    model_ok = 1'b0;
    rst = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_rvalid", 64'(rvalid_o[i]), 64'd0);
      chk("rst_rdata", rdata_o[i], 64'd0);
      chk("rst_rerr", 64'(rerr_o[i]), 64'd0);
      chk("rst_req_ready", 64'(rdy_o[i]), 64'd1);
      chk("rst_mtime", mtime_o[i], 64'd0);
      chk("rst_mtip", 64'(mtip_o[i]), 64'd0);
      chk("rst_msip", 64'(msip_o[i]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      anc_v[i]  = 64'd0;
      anc_e[i]  = cyc;
      cmp_m[i]  = '1;
      msip_m[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
    model_ok = 1'b1;
  endtask

  // Issues one request; it is accepted at the next edge, whose number is recorded as A.
  task automatic do_req(input int i, input logic [63:0] addr, input logic wen,
                        input logic [63:0] wd, input logic [7:0] wm);
    logic [63:0] off, old, m, merged;
    logic        err;
    int          a;
    exp_t        e;
    @(posedge clk);
    #1;
    a = cyc + 1;
    chk("req_ready_idle", 64'(rdy_o[i]), 64'd1);
    off = addr - BASE;
    err = (addr < BASE) || (off >= 64'h1_0000) || (addr[2:0] != 3'b000) ||
          !((off == 64'h0) || (off == 64'h4000) || (off == 64'hBFF8));
    old = 64'd0;
    if (!err) begin
      if (off == 64'h0)         old = {63'd0, msip_m[i]};
      else if (off == 64'h4000) old = cmp_m[i];
      else                      old = ref_mtime(i, a - 1);
    end
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{wm[b]}};
    merged  = (wd & m) | (old & ~m);
    e.rdata = old;
    e.rerr  = err;
    e.cyc   = 32'(a);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    rv[i] = 1'b1; ra[i] = addr; rw[i] = wen; rwd[i] = wd; rm[i] = wm;
    @(posedge clk);
    #1;
    rv[i] = 1'b0;
    chk("req_ready_resp", 64'(rdy_o[i]), 64'd0);
    if (wen && !err) begin
      if (off == 64'h0) begin
        if (wm[0]) msip_m[i] = wd[0];
      end else if (off == 64'h4000) begin
        cmp_m[i] = merged;
      end else if (wm != 8'h00) begin
        anc_v[i] = merged;
        anc_e[i] = a;
      end
    end
  endtask

  initial begin
    logic [63:0] addr, wd;
    logic [7:0]  wm;
    int          tgt, inst, wsel;

    do_reset(3);

    // Free-running mtime after reset.
    repeat (10) @(posedge clk);
    #1;
    chk("idle10_mtime", mtime_o[0], 64'd10);
    chk("idle10_mtip", 64'(mtip_o[0]), 64'd0);
    chk("idle10_msip", 64'(msip_o[0]), 64'd0);
    chk("idle10_ready", 64'(rdy_o[0]), 64'd1);

    // mtimecmp = 20: mtip rises exactly when mtime reaches 20 and stays up.
    do_req(0, BASE + 64'h4000, 1'b1, 64'd20, 8'hFF);
    for (int w = 0; w < 40 && mtime_o[0] != 64'd20; w++) begin
      @(posedge clk);
      #1;
    end
    chk("cmp20_reached", mtime_o[0], 64'd20);
    chk("cmp20_mtip", 64'(mtip_o[0]), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("cmp20_mtip_hold", 64'(mtip_o[0]), 64'd1);

    // MSIP: only bit 0 with wmask[0]; zero mask is a no-op.
    do_req(0, BASE, 1'b1, 64'hFFFF_FFFF, 8'h01);
    chk("msip_set", 64'(msip_o[0]), 64'd1);
    do_req(0, BASE, 1'b0, 64'd0, 8'h00);
    do_req(0, BASE, 1'b1, 64'd0, 8'h00);
    chk("msip_mask0", 64'(msip_o[0]), 64'd1);

    // mtime wrap around 2^64 against mtimecmp = all ones.
    do_req(0, BASE + 64'h4000, 1'b1, '1, 8'hFF);
    do_req(0, BASE + 64'hBFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    chk("wrap_fe", mtime_o[0], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap_fe_mtip", 64'(mtip_o[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("wrap_ff", mtime_o[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_ff_mtip", 64'(mtip_o[0]), 64'd1);
    @(posedge clk);
    #1;
    chk("wrap_00", mtime_o[0], 64'd0);
    chk("wrap_00_mtip", 64'(mtip_o[0]), 64'd0);

    // Divider 4: a write landing on the tick edge suppresses that tick.
    for (int w = 0; w < 4 && ((cyc + 2 - anc_e[1]) % 4) != 0; w++) begin
      @(posedge clk);
      #1;
    end
    do_req(1, BASE + 64'hBFF8, 1'b1, 64'd100, 8'hFF);
    chk("div4_load", mtime_o[1], 64'd100);
    repeat (3) @(posedge clk);
    #1;
    chk("div4_hold", mtime_o[1], 64'd100);
    @(posedge clk);
    #1;
    chk("div4_tick", mtime_o[1], 64'd101);

    // Error accesses.
    do_req(0, BASE + 64'h0008, 1'b0, 64'd0, 8'h00);
    do_req(0, BASE + 64'hBFFC, 1'b0, 64'd0, 8'h00);
    do_req(0, BASE + 64'h4004, 1'b1, '1, 8'hFF);
    do_req(0, BASE + 64'h1_0000, 1'b1, '1, 8'hFF);

    // Reset while the response is showing.
    do_req(0, BASE + 64'h4000, 1'b0, 64'd0, 8'h00);
    do_reset(1);

    // Reset in the same cycle as an accepted request discards it.
    @(posedge clk);
    #1;
    model_ok = 1'b0;
    rst = 1'b0;
    rv[0] = 1'b1; ra[0] = BASE; rw[0] = 1'b1; rwd[0] = 64'd1; rm[0] = 8'hFF;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    @(negedge clk);
    chk("rst_req_rvalid", 64'(rvalid_o[0]), 64'd0);
    chk("rst_req_msip", 64'(msip_o[0]), 64'd0);
    do_reset(1);

    // Random traffic.
    for (int t = 0; t < 300; t++) begin
      inst = ($urandom_range(0, 3) == 0) ? 1 : 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      tgt = $urandom_range(0, 7);
      case (tgt)
        0:       addr = BASE;
        1, 2:    addr = BASE + 64'h4000;
        3, 4:    addr = BASE + 64'hBFF8;
        5:       addr = BASE + {48'd0, 13'($urandom_range(0, 8191)), 3'b000};
        6:       addr = BASE + 64'h4000 + 64'($urandom_range(1, 7));
        default: addr = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 1) == 0)
        wd = ref_mtime(inst, cyc) + 64'($urandom_range(0, 24));
      else
        wd = {$urandom, $urandom};
      wsel = $urandom_range(0, 7);
      if (wsel == 0)      wm = 8'h00;
      else if (wsel < 4)  wm = 8'hFF;
      else                wm = 8'($urandom_range(0, 255));
      do_req(inst, addr, 1'($urandom_range(0, 1)), wd, wm);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
